// File: rtl/logic_axi4_stream_mux_pkg.sv
// Shared definitions for the round-robin AXI4-Stream multiplexer.
//   sel_width() : width of a channel index for a given channel count
//   state_t     : packet-lock FSM states
package logic_axi4_stream_mux_pkg;

  // A single channel still needs a one-bit index so that ports never collapse to zero width.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/logic_arbiter_round_robin.sv
// Combinational round-robin arbiter.
// The search starts at pointer+1 and wraps modulo INPUTS, so the channel
// named by pointer (the last one served) has the lowest priority.
// Ports:
//   request      in   INPUTS     pending requests, one bit per channel
//   pointer      in   SEL_WIDTH  index of the channel served last
//   grant_onehot out  INPUTS     one-hot winner (all zero when nothing requests)
//   grant_index  out  SEL_WIDTH  winner index (equals pointer when nothing requests)
//   grant_valid  out  1          at least one request is pending
module logic_arbiter_round_robin
  import logic_axi4_stream_mux_pkg::*;
#(
  parameter int INPUTS = 2
) (
  input  logic [INPUTS-1:0]            request,
  input  logic [sel_width(INPUTS)-1:0] pointer,
  output logic [INPUTS-1:0]            grant_onehot,
  output logic [sel_width(INPUTS)-1:0] grant_index,
  output logic                         grant_valid
);

  localparam int SEL_WIDTH = sel_width(INPUTS);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin : search
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_index  = pointer;
    grant_valid  = 1'b0;
    for (int k = 1; k <= INPUTS; k++) begin
      idx = (int'(pointer) + k) % INPUTS;
      if (!grant_valid && request[idx]) begin
        grant_valid       = 1'b1;
        grant_index       = SEL_WIDTH'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_axi4_stream_mux_rr.sv
// Packet-aware N:1 AXI4-Stream multiplexer with round-robin arbitration.
// In IDLE the arbiter picks the next valid channel after the last one served;
// a beat without tlast locks the grant until that packet's tlast beat has
// passed (USE_TLAST=1). The Tx stage is a single register that refills on
// bubbles, so throughput is one beat per cycle with one cycle of latency.
// Channels that are not selected see tready=0 and are never drained.
//
// Optional feature (compile-time macro):
//   LOGIC_AXI4_STREAM_MUX_RR_SOURCE_TID_EN  replace tx_tid[SEL_WIDTH-1:0] with the
//                                           source channel index (requires
//                                           TID_WIDTH >= SEL_WIDTH); undefined:
//                                           tid passes through unchanged.
// Ports (rx_* buses are channel-major: channel i occupies slice i):
//   aclk, areset_n          clock, asynchronous active-low reset
//   rx_tvalid/rx_tready     per-channel handshake
//   rx_tdata/tkeep/tstrb/tlast/tid/tdest/tuser   per-channel payload
//   tx_tvalid/tx_tready     output handshake
//   tx_tdata/tkeep/tstrb/tlast/tid/tdest/tuser   output payload (registered)
//   grant                   currently selected channel
//   locked                  a packet is in progress on grant
module logic_axi4_stream_mux_rr
  import logic_axi4_stream_mux_pkg::*;
#(
  parameter int INPUTS      = 2,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TLAST   = 1,
  parameter int USE_TKEEP   = 1,
  parameter int USE_TSTRB   = 1
) (
  input  logic                              aclk,
  input  logic                              areset_n,

  input  logic [INPUTS-1:0]                 rx_tvalid,
  output logic [INPUTS-1:0]                 rx_tready,
  input  logic [INPUTS*TDATA_BYTES*8-1:0]   rx_tdata,
  input  logic [INPUTS*TDATA_BYTES-1:0]     rx_tkeep,
  input  logic [INPUTS*TDATA_BYTES-1:0]     rx_tstrb,
  input  logic [INPUTS-1:0]                 rx_tlast,
  input  logic [INPUTS*TID_WIDTH-1:0]       rx_tid,
  input  logic [INPUTS*TDEST_WIDTH-1:0]     rx_tdest,
  input  logic [INPUTS*TUSER_WIDTH-1:0]     rx_tuser,

  output logic                              tx_tvalid,
  input  logic                              tx_tready,
  output logic [TDATA_BYTES*8-1:0]          tx_tdata,
  output logic [TDATA_BYTES-1:0]            tx_tkeep,
  output logic [TDATA_BYTES-1:0]            tx_tstrb,
  output logic                              tx_tlast,
  output logic [TID_WIDTH-1:0]              tx_tid,
  output logic [TDEST_WIDTH-1:0]            tx_tdest,
  output logic [TUSER_WIDTH-1:0]            tx_tuser,

  output logic [sel_width(INPUTS)-1:0]      grant,
  output logic                              locked
);

  localparam int SEL_WIDTH = sel_width(INPUTS);
  localparam int DW        = TDATA_BYTES * 8;

  if (INPUTS < 2) begin : g_inputs_check
    $error("logic_axi4_stream_mux_rr: INPUTS must be at least 2");
  end

`ifdef LOGIC_AXI4_STREAM_MUX_RR_SOURCE_TID_EN
  if (TID_WIDTH < SEL_WIDTH) begin : g_tid_check
    $error("logic_axi4_stream_mux_rr: TID_WIDTH must be at least SEL_WIDTH for source tid");
  end
`endif

  state_t                 state;
  logic [SEL_WIDTH-1:0]   ptr;
  logic [SEL_WIDTH-1:0]   grant_q;
  logic [SEL_WIDTH-1:0]   sel;
  logic [SEL_WIDTH-1:0]   arb_index;
  logic [INPUTS-1:0]      arb_onehot_unused;
  logic                   arb_valid;
  logic                   load;
  logic                   xfer;

  logic [DW-1:0]          sel_tdata;
  logic [TDATA_BYTES-1:0] sel_tkeep;
  logic [TDATA_BYTES-1:0] sel_tstrb;
  logic                   sel_tlast;
  logic [TID_WIDTH-1:0]   sel_tid;
  logic [TDEST_WIDTH-1:0] sel_tdest;
  logic [TUSER_WIDTH-1:0] sel_tuser;

  logic_arbiter_round_robin #(
    .INPUTS (INPUTS)
  ) u_arbiter (
    .request      (rx_tvalid),
    .pointer      (ptr),
    .grant_onehot (arb_onehot_unused),
    .grant_index  (arb_index),
    .grant_valid  (arb_valid)
  );

  // While locked only the granted channel is considered; with nothing pending
  // the selection parks on ptr so the output stage simply loads a bubble.
  always_comb begin
    if (state == LOCKED) begin
      sel = grant_q;
    end else if (arb_valid) begin
      sel = arb_index;
    end else begin
      sel = ptr;
    end
  end

  // The output register can accept a new beat when it is empty or being drained.
  assign load = !tx_tvalid || tx_tready;
  assign xfer = load && rx_tvalid[sel];

  // tready is gated by reset so no source sees a handshake while the mux is held.
  always_comb begin
    for (int i = 0; i < INPUTS; i++) begin
      rx_tready[i] = load && areset_n && (sel == SEL_WIDTH'(i));
    end
  end

  assign grant  = areset_n ? sel : '0;
  assign locked = (state == LOCKED);

  // Payload selection for the chosen channel.
  assign sel_tdata = rx_tdata[sel*DW +: DW];
  assign sel_tlast = rx_tlast[sel];
  assign sel_tdest = rx_tdest[sel*TDEST_WIDTH +: TDEST_WIDTH];
  assign sel_tuser = rx_tuser[sel*TUSER_WIDTH +: TUSER_WIDTH];

  if (USE_TKEEP != 0) begin : g_tkeep
    assign sel_tkeep = rx_tkeep[sel*TDATA_BYTES +: TDATA_BYTES];
  end else begin : g_no_tkeep
    logic unused_tkeep;
    assign unused_tkeep = ^rx_tkeep;
    assign sel_tkeep    = '1;
  end

  if (USE_TSTRB != 0) begin : g_tstrb
    assign sel_tstrb = rx_tstrb[sel*TDATA_BYTES +: TDATA_BYTES];
  end else begin : g_no_tstrb
    logic unused_tstrb;
    assign unused_tstrb = ^rx_tstrb;
    assign sel_tstrb    = '1;
  end

  always_comb begin
    sel_tid = rx_tid[sel*TID_WIDTH +: TID_WIDTH];
`ifdef LOGIC_AXI4_STREAM_MUX_RR_SOURCE_TID_EN
    sel_tid[SEL_WIDTH-1:0] = sel;
`endif
  end

  // FSM, round-robin pointer and output valid.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      ptr       <= SEL_WIDTH'(INPUTS - 1);
      grant_q   <= '0;
      tx_tvalid <= 1'b0;
    end else begin
      if (load) begin
        tx_tvalid <= rx_tvalid[sel];
      end
      if (xfer) begin
        ptr <= sel;
        case (state)
          IDLE: begin
            if ((USE_TLAST != 0) && !sel_tlast) begin
              state   <= LOCKED;
              grant_q <= sel;
            end
          end
          LOCKED: begin
            if (sel_tlast) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: the payload register has no reset; tx_tvalid qualifies it, and
  // leaving data flops unreset keeps them off the reset tree.
  always_ff @(posedge aclk) begin
    if (load) begin
      tx_tdata <= sel_tdata;
      tx_tkeep <= sel_tkeep;
      tx_tstrb <= sel_tstrb;
      tx_tlast <= sel_tlast;
      tx_tid   <= sel_tid;
      tx_tdest <= sel_tdest;
      tx_tuser <= sel_tuser;
    end
  end

endmodule

// File: tb/tb_logic_axi4_stream_mux_rr.sv
// Directed bench for logic_axi4_stream_mux_rr with four channels.
// Each source presents beats tdata = {channel, beat_count}; a source advances
// its beat count when it sees a handshake. tdest/tuser/tstrb are derived from
// the channel index and tid is 4'hC on every channel.
module tb_logic_axi4_stream_mux_rr;

  localparam int N  = 4;
  localparam int SW = 2;

  logic             aclk;
  logic             areset_n;
  logic [N-1:0]     rx_tvalid;
  logic [N-1:0]     rx_tready;
  logic [N*8-1:0]   rx_tdata;
  logic [N-1:0]     rx_tkeep;
  logic [N-1:0]     rx_tstrb;
  logic [N-1:0]     rx_tlast;
  logic [N*4-1:0]   rx_tid;
  logic [N*2-1:0]   rx_tdest;
  logic [N-1:0]     rx_tuser;
  logic             tx_tvalid;
  logic             tx_tready;
  logic [7:0]       tx_tdata;
  logic [0:0]       tx_tkeep;
  logic [0:0]       tx_tstrb;
  logic             tx_tlast;
  logic [3:0]       tx_tid;
  logic [1:0]       tx_tdest;
  logic [0:0]       tx_tuser;
  logic [SW-1:0]    grant;
  logic             locked;

  logic [3:0]       cnt [N];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] v;    // rx_tvalid
    logic [3:0] l;    // rx_tlast
    logic       r;    // tx_tready
    logic [3:0] rdy;  // expected rx_tready before the edge
    logic [1:0] gnt;  // expected grant before the edge
    logic       lk;   // expected locked before the edge
    logic       tv;   // expected tx_tvalid after the edge
    logic [7:0] td;   // expected tx_tdata after the edge (when tv)
    logic       tl;   // expected tx_tlast after the edge (when tv)
  } step_t;

  step_t tbl [23];

  logic_axi4_stream_mux_rr #(
    .INPUTS      (N),
    .TDATA_BYTES (1),
    .TDEST_WIDTH (2),
    .TUSER_WIDTH (1),
    .TID_WIDTH   (4),
    .USE_TLAST   (1),
    .USE_TKEEP   (1),
    .USE_TSTRB   (1)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .rx_tvalid (rx_tvalid),
    .rx_tready (rx_tready),
    .rx_tdata  (rx_tdata),
    .rx_tkeep  (rx_tkeep),
    .rx_tstrb  (rx_tstrb),
    .rx_tlast  (rx_tlast),
    .rx_tid    (rx_tid),
    .rx_tdest  (rx_tdest),
    .rx_tuser  (rx_tuser),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .tx_tdata  (tx_tdata),
    .tx_tkeep  (tx_tkeep),
    .tx_tstrb  (tx_tstrb),
    .tx_tlast  (tx_tlast),
    .tx_tid    (tx_tid),
    .tx_tdest  (tx_tdest),
    .tx_tuser  (tx_tuser),
    .grant     (grant),
    .locked    (locked)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rx_tdata[i*8 +: 8] = {4'(i), cnt[i]};
      rx_tdest[i*2 +: 2] = 2'(i);
      rx_tuser[i]        = ((i % 2) == 1);
      rx_tstrb[i]        = ((i % 2) == 1);
      rx_tkeep[i]        = 1'b1;
      rx_tid[i*4 +: 4]   = 4'hC;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_tid(input logic [1:0] src);
`ifdef LOGIC_AXI4_STREAM_MUX_RR_SOURCE_TID_EN
    return {2'b11, src};
`else
    return (src == src) ? 4'hC : 4'hC;
`endif
  endfunction

  // One cycle: drive inputs, check the combinational view, clock, then check Tx.
  task automatic apply(input int id, input step_t s);
    logic [3:0] hs;
    rx_tvalid = s.v;
    rx_tlast  = s.l;
    tx_tready = s.r;
    #1;
    check($sformatf("rx_tready[%0d]", id), 32'(rx_tready), 32'(s.rdy));
    check($sformatf("grant[%0d]", id), 32'(grant), 32'(s.gnt));
    check($sformatf("locked[%0d]", id), 32'(locked), 32'(s.lk));
    hs = rx_tready & rx_tvalid;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) cnt[i] = cnt[i] + 4'd1;
    end
    check($sformatf("tx_tvalid[%0d]", id), 32'(tx_tvalid), 32'(s.tv));
    if (s.tv) begin
      check($sformatf("tx_tdata[%0d]", id), 32'(tx_tdata), 32'(s.td));
      check($sformatf("tx_tlast[%0d]", id), 32'(tx_tlast), 32'(s.tl));
      check($sformatf("tx_tid[%0d]", id), 32'(tx_tid), 32'(exp_tid(s.td[5:4])));
      check($sformatf("tx_tdest[%0d]", id), 32'(tx_tdest), 32'(s.td[5:4]));
      check($sformatf("tx_tuser[%0d]", id), 32'(tx_tuser), 32'(s.td[4]));
      check($sformatf("tx_tstrb[%0d]", id), 32'(tx_tstrb), 32'(s.td[4]));
      check($sformatf("tx_tkeep[%0d]", id), 32'(tx_tkeep), 32'd1);
    end
  endtask

  initial begin
    //            v     l     r     rdy   gnt   lk    tv    td     tl
    // Round robin over four always-valid single-beat sources.
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 2'd1, 1'b0, 1'b1, 8'h10, 1'b1};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 2'd2, 1'b0, 1'b1, 8'h20, 1'b1};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 2'd3, 1'b0, 1'b1, 8'h30, 1'b1};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 1'b0, 1'b1, 8'h01, 1'b1};
    // Move the pointer to 3 so channel 0 is next.
    tbl[5]  = '{4'h8, 4'hF, 1'b1, 4'h8, 2'd3, 1'b0, 1'b1, 8'h31, 1'b1};
    // Three-beat packet on rx0 while rx1 waits; rx1 follows immediately.
    tbl[6]  = '{4'h3, 4'hE, 1'b1, 4'h1, 2'd0, 1'b0, 1'b1, 8'h02, 1'b0};
    tbl[7]  = '{4'h3, 4'hE, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 8'h03, 1'b0};
    tbl[8]  = '{4'h3, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 8'h04, 1'b1};
    tbl[9]  = '{4'h3, 4'hF, 1'b1, 4'h2, 2'd1, 1'b0, 1'b1, 8'h11, 1'b1};
    // Back-pressure for five cycles in the middle of an rx2 packet.
    tbl[10] = '{4'h4, 4'hB, 1'b1, 4'h4, 2'd2, 1'b0, 1'b1, 8'h21, 1'b0};
    tbl[11] = '{4'h4, 4'hF, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1, 8'h21, 1'b0};
    tbl[12] = '{4'h4, 4'hF, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1, 8'h21, 1'b0};
    tbl[13] = '{4'h4, 4'hF, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1, 8'h21, 1'b0};
    tbl[14] = '{4'h4, 4'hF, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1, 8'h21, 1'b0};
    tbl[15] = '{4'h4, 4'hF, 1'b0, 4'h0, 2'd2, 1'b1, 1'b1, 8'h21, 1'b0};
    tbl[16] = '{4'h4, 4'hF, 1'b1, 4'h4, 2'd2, 1'b1, 1'b1, 8'h22, 1'b1};
    // rx2 packet with a two-cycle tvalid gap while rx3 is waiting.
    tbl[17] = '{4'h4, 4'hB, 1'b1, 4'h4, 2'd2, 1'b0, 1'b1, 8'h23, 1'b0};
    tbl[18] = '{4'h8, 4'hB, 1'b1, 4'h4, 2'd2, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[19] = '{4'h8, 4'hB, 1'b1, 4'h4, 2'd2, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[20] = '{4'hC, 4'hF, 1'b1, 4'h4, 2'd2, 1'b1, 1'b1, 8'h24, 1'b1};
    tbl[21] = '{4'h8, 4'hF, 1'b1, 4'h8, 2'd3, 1'b0, 1'b1, 8'h32, 1'b1};
    // Nothing pending: selection parks on the pointer and a bubble loads.
    tbl[22] = '{4'h0, 4'hF, 1'b1, 4'h8, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0};

    for (int i = 0; i < N; i++) cnt[i] = 4'd0;
    areset_n  = 1'b0;
    rx_tvalid = 4'hF;
    rx_tlast  = 4'hF;
    tx_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset tx_tvalid", 32'(tx_tvalid), 32'd0);
    check("reset locked", 32'(locked), 32'd0);
    check("reset grant", 32'(grant), 32'd0);
    check("reset rx_tready", 32'(rx_tready), 32'd0);
    @(negedge aclk);
    areset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      apply(i, tbl[i]);
    end

    // Reset in the middle of an rx1 packet aborts the lock.
    apply(100, '{4'h2, 4'hD, 1'b1, 4'h2, 2'd1, 1'b0, 1'b1, 8'h12, 1'b0});
    check("locked before reset", 32'(locked), 32'd1);
    areset_n = 1'b0;
    #1;
    check("mid-packet reset tx_tvalid", 32'(tx_tvalid), 32'd0);
    check("mid-packet reset locked", 32'(locked), 32'd0);
    check("mid-packet reset grant", 32'(grant), 32'd0);
    check("mid-packet reset rx_tready", 32'(rx_tready), 32'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    // Pointer is back at 3, so the lowest valid index (rx2) wins first.
    apply(101, '{4'hC, 4'hF, 1'b1, 4'h4, 2'd2, 1'b0, 1'b1, 8'h25, 1'b1});
    apply(102, '{4'h8, 4'hF, 1'b1, 4'h8, 2'd3, 1'b0, 1'b1, 8'h33, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
